// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V IF stage with PC, single-outstanding imem handshake,
// one-entry holding buffer and IF/ID register. Optional perf counters: FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_KILL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;

    logic        r_buf_valid;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;

    logic        r_id_valid;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc;

    logic        w_resp;
    logic        w_req;
    logic        w_fire;

    // A response only belongs to us in WAIT; in KILL or IDLE it is stale.
    assign w_resp = (r_state == S_WAIT) && imem_rvalid;

    // No issue while the buffer is full, so a buffered instruction is never overwritten.
    assign w_req  = !rst && !redirect_valid && !r_buf_valid &&
                    ((r_state == S_IDLE) || (w_resp && !stall));
    assign w_fire = w_req && imem_gnt;

    assign imem_req  = w_req;
    assign imem_addr = r_pc;

    always_comb begin
        // NOTE: default assigned first so every path drives it and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fire) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)   w_state_nxt = imem_rvalid ? S_IDLE : S_KILL;
                else if (imem_rvalid) w_state_nxt = w_fire ? S_WAIT : S_IDLE;
            end
            S_KILL: begin
                if (imem_rvalid) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_buf_valid <= 1'b0;
            r_buf_inst  <= NOP_INST;
            r_buf_pc    <= '0;
            r_id_valid  <= 1'b0;
            r_id_inst   <= NOP_INST;
            r_id_pc     <= '0;
        end else begin
            if (redirect_valid) r_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (w_fire)    r_pc <= r_pc + 32'd4;

            if (w_fire) r_req_pc <= r_pc;

            // The buffer catches a response that IF/ID cannot take this cycle.
            if (redirect_valid) begin
                r_buf_valid <= 1'b0;
            end else if (w_resp && (stall || r_buf_valid)) begin
                r_buf_valid <= 1'b1;
                r_buf_inst  <= imem_rdata;
                r_buf_pc    <= r_req_pc;
            end else if (!stall) begin
                r_buf_valid <= 1'b0;
            end

            if (redirect_valid) begin
                r_id_valid <= 1'b0;
                r_id_inst  <= NOP_INST;
            end else if (!stall) begin
                if (r_buf_valid) begin
                    r_id_valid <= 1'b1;
                    r_id_inst  <= r_buf_inst;
                    r_id_pc    <= r_buf_pc;
                end else if (w_resp) begin
                    r_id_valid <= 1'b1;
                    r_id_inst  <= imem_rdata;
                    r_id_pc    <= r_req_pc;
                end else begin
                    r_id_valid <= 1'b0;
                    r_id_inst  <= NOP_INST;
                end
            end
        end
    end

    assign id_valid = r_id_valid;
    assign id_inst  = r_id_inst;
    assign id_pc    = r_id_pc;

`ifdef FETCH_PERF_EN
    logic        w_id_load_valid;
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    assign w_id_load_valid = !stall && !redirect_valid && (r_buf_valid || w_resp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_id_load_valid)         r_perf_fetch <= r_perf_fetch + 32'd1;
            if (stall && !redirect_valid) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: program-order stream scoreboard plus
// directed cycle-exact checks of latency, stall, redirect, reset and wrap.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    // Second instance only exercises the RESET_PC wrap-around.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_id_valid;
    logic [31:0] w_id_inst;
    logic [31:0] w_id_pc;
    logic [31:0] w_perf_fetch;
    logic [31:0] w_perf_stall;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(w_id_valid), .id_inst(w_id_inst), .id_pc(w_id_pc),
        .perf_fetch_cnt(w_perf_fetch), .perf_stall_cnt(w_perf_stall)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: one outstanding request, response mem_lat cycles after grant.
    // Pending responses survive reset on purpose, to model a late rvalid.
    int          mem_lat = 1;
    int          m_cnt = 0;
    bit          m_pend = 1'b0;
    logic [31:0] m_paddr = '0;
    bit          s_fire = 1'b0;
    logic [31:0] s_addr = '0;

    initial forever begin
        @(negedge clk);
        s_fire = imem_req && imem_gnt;
        s_addr = imem_addr;
    end

    initial forever begin
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(m_paddr);
                m_pend      = 1'b0;
            end
        end
        if (s_fire) begin
            m_paddr = s_addr;
            m_cnt   = mem_lat - 1;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(s_addr);
            end else begin
                m_pend = 1'b1;
            end
        end
    end

    // Stream model: grants must walk the program order, valid IF/ID entries must
    // appear once each in program order, stalls freeze IF/ID, redirects restart both.
    logic [31:0] m_issue_pc = '0;
    logic [31:0] m_id_pc = '0;
    logic [31:0] m_fetch = '0;
    logic [31:0] m_stall = '0;
    bit          prev_stall = 1'b0;
    bit          prev_redir = 1'b0;
    logic        h_valid = 1'b0;
    logic [31:0] h_inst = '0;
    logic [31:0] h_pc = '0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("rst_req", {31'b0, imem_req}, 32'd0);
            check("rst_id_valid", {31'b0, id_valid}, 32'd0);
            check("rst_id_inst", id_inst, NOP);
            check("rst_id_pc", id_pc, 32'd0);
            check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
            check("rst_perf_stall", perf_stall_cnt, 32'd0);
            m_issue_pc = 32'd0;
            m_id_pc    = 32'd0;
            m_fetch    = '0;
            m_stall    = '0;
            prev_stall = 1'b0;
            prev_redir = 1'b0;
        end else begin
            if (prev_redir) check("flush_valid", {31'b0, id_valid}, 32'd0);
            if (prev_stall && !prev_redir) begin
                check("hold_valid", {31'b0, id_valid}, {31'b0, h_valid});
                check("hold_inst", id_inst, h_inst);
                check("hold_pc", id_pc, h_pc);
            end else if (id_valid) begin
                check("stream_pc", id_pc, m_id_pc);
                check("stream_inst", id_inst, mem_word(m_id_pc));
                m_id_pc = m_id_pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end else begin
                check("bubble_inst", id_inst, NOP);
            end
            check("perf_fetch", perf_fetch_cnt, PERF ? m_fetch : 32'd0);
            check("perf_stall", perf_stall_cnt, PERF ? m_stall : 32'd0);
            check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (redirect_valid) check("redir_req_low", {31'b0, imem_req}, 32'd0);
            if (imem_req && imem_gnt) begin
                check("issue_addr", imem_addr, m_issue_pc);
                m_issue_pc = m_issue_pc + 32'd4;
            end
            if (redirect_valid) begin
                m_issue_pc = {redirect_pc[31:2], 2'b00};
                m_id_pc    = {redirect_pc[31:2], 2'b00};
            end
            if (stall && !redirect_valid) m_stall = m_stall + 32'd1;
            h_valid    = id_valid;
            h_inst     = id_inst;
            h_pc       = id_pc;
            prev_stall = stall;
            prev_redir = redirect_valid;
        end
    end

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Leaves the caller at the start of the first cycle after release (c1).
    task automatic apply_reset();
        cycle_start();
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b1;
        repeat (3) cycle_start();
        sample();
        cycle_start();
        rst = 1'b0;
    endtask

    initial begin
        // Latency and steady-state throughput, plus RESET_PC wrap on the second instance.
        apply_reset();
        sample();
        check("t1_c1_req", {31'b0, imem_req}, 32'd1);
        check("t1_c1_addr", imem_addr, 32'h0000_0000);
        check("t1_c1_valid", {31'b0, id_valid}, 32'd0);
        check("wrap_c1_req", {31'b0, w_req}, 32'd1);
        check("wrap_c1_addr", w_addr, 32'hFFFF_FFFC);
        check("wrap_c1_inst", w_id_inst, NOP);
        check("wrap_c1_perf", w_perf_fetch | w_perf_stall, 32'd0);
        cycle_start(); sample();
        check("t1_c2_addr", imem_addr, 32'h0000_0004);
        check("wrap_c2_addr", w_addr, 32'h0000_0000);
        cycle_start(); sample();
        check("t1_c3_addr", imem_addr, 32'h0000_0008);
        check("t1_c3_valid", {31'b0, id_valid}, 32'd1);
        check("t1_c3_pc", id_pc, 32'h0000_0000);
        check("t1_c3_inst", id_inst, 32'hBEEF_0000);
        check("wrap_c3_valid", {31'b0, w_id_valid}, 32'd1);
        check("wrap_c3_pc", w_id_pc, 32'hFFFF_FFFC);
        cycle_start(); sample();
        check("t1_c4_pc", id_pc, 32'h0000_0004);
        check("t1_c4_inst", id_inst, 32'hBEEB_0004);

        // Three stall cycles while the response for PC 4 arrives.
        apply_reset();
        cycle_start();
        cycle_start();
        stall = 1'b1;
        for (int c = 3; c <= 5; c++) begin
            sample();
            check("t2_stall_req", {31'b0, imem_req}, 32'd0);
            check("t2_stall_pc", id_pc, 32'h0000_0000);
            check("t2_stall_valid", {31'b0, id_valid}, 32'd1);
            if (c < 5) cycle_start();
        end
        cycle_start();
        stall = 1'b0;
        sample();
        check("t2_c6_req", {31'b0, imem_req}, 32'd0);
        check("t2_c6_pc", id_pc, 32'h0000_0000);
        cycle_start(); sample();
        check("t2_c7_valid", {31'b0, id_valid}, 32'd1);
        check("t2_c7_pc", id_pc, 32'h0000_0004);
        check("t2_c7_inst", id_inst, 32'hBEEB_0004);
        check("t2_c7_req", {31'b0, imem_req}, 32'd1);
        check("t2_c7_addr", imem_addr, 32'h0000_0008);
        cycle_start(); sample();
        check("t2_c8_valid", {31'b0, id_valid}, 32'd0);
        cycle_start(); sample();
        check("t2_c9_pc", id_pc, 32'h0000_0008);
        check("t2_c9_inst", id_inst, 32'hBEE7_0008);

        // Redirect to an unaligned target while the 3-cycle response is outstanding.
        apply_reset();
        mem_lat = 3;
        sample();
        check("t3_c1_addr", imem_addr, 32'h0000_0000);
        cycle_start();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        sample();
        check("t3_c2_req", {31'b0, imem_req}, 32'd0);
        cycle_start();
        redirect_valid = 1'b0;
        sample();
        check("t3_c3_req", {31'b0, imem_req}, 32'd0);
        cycle_start(); sample();
        check("t3_c4_kill_req", {31'b0, imem_req}, 32'd0);
        cycle_start(); sample();
        check("t3_c5_req", {31'b0, imem_req}, 32'd1);
        check("t3_c5_addr", imem_addr, 32'h0000_0100);
        check("t3_c5_valid", {31'b0, id_valid}, 32'd0);
        repeat (3) cycle_start();
        sample();
        check("t3_c8_valid", {31'b0, id_valid}, 32'd0);
        cycle_start(); sample();
        check("t3_c9_valid", {31'b0, id_valid}, 32'd1);
        check("t3_c9_pc", id_pc, 32'h0000_0100);
        check("t3_c9_inst", id_inst, 32'hBFEF_0100);

        // Redirect and stall together: the flush wins; target lands at N+3.
        apply_reset();
        mem_lat = 1;
        repeat (3) cycle_start();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        sample();
        check("t4_n_req", {31'b0, imem_req}, 32'd0);
        cycle_start();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        sample();
        check("t4_n1_valid", {31'b0, id_valid}, 32'd0);
        check("t4_n1_inst", id_inst, 32'h0000_0013);
        check("t4_n1_pc", id_pc, 32'h0000_0004);
        check("t4_n1_addr", imem_addr, 32'h0000_0200);
        repeat (2) cycle_start();
        sample();
        check("t4_n3_valid", {31'b0, id_valid}, 32'd1);
        check("t4_n3_pc", id_pc, 32'h0000_0200);
        check("t4_n3_inst", id_inst, 32'hBCEF_0200);

        // Reset mid-transaction; the late response lands while IDLE and is ignored.
        apply_reset();
        mem_lat = 4;
        cycle_start();
        rst = 1'b1;
        cycle_start();
        cycle_start();
        rst      = 1'b0;
        imem_gnt = 1'b0;
        sample();
        check("t5_c4_req", {31'b0, imem_req}, 32'd1);
        cycle_start();
        cycle_start();
        imem_gnt = 1'b1;
        mem_lat  = 1;
        sample();
        check("t5_c6_valid", {31'b0, id_valid}, 32'd0);
        check("t5_c6_inst", id_inst, NOP);
        repeat (2) cycle_start();
        sample();
        check("t5_c8_valid", {31'b0, id_valid}, 32'd1);
        check("t5_c8_pc", id_pc, 32'h0000_0000);

        // Ten fetched instructions and four stall cycles.
        apply_reset();
        stall = 1'b1;
        repeat (4) cycle_start();
        stall = 1'b0;
        repeat (11) cycle_start();
        sample();
        check("t6_perf_fetch", perf_fetch_cnt, PERF ? 32'd10 : 32'd0);
        check("t6_perf_stall", perf_stall_cnt, PERF ? 32'd4 : 32'd0);

        cycle_start();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
